// File: rtl/stream_serializer.sv
// Wide-to-narrow stream serializer: each WIDTH-bit word leaves as RATIO beats of OWIDTH bits, LSB slice first.
// Latency: first beat is valid the cycle after the word is accepted; sustained rate is one beat per cycle.
// Backpressure: downstream stall freezes the current beat; the next word is taken on the last-beat handshake with no bubble.
//
// Ports:
//   i_clk, i_reset         single rising-edge clock, synchronous active-high reset
//   i_input_valid/o_input_ready/i_input_data     upstream wide word (valid/ready)
//   o_output_valid/i_output_ready/o_output_data  downstream narrow beat (valid/ready)
//   o_output_last          beat is the final slice of its word
//
// Parameters: WIDTH must be an integer multiple of RATIO, and RATIO must be at least 2.

module stream_serializer #(
   parameter int WIDTH = 32,
   parameter int RATIO = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_input_valid,
   output logic                     o_input_ready,
   input  logic [WIDTH-1:0]         i_input_data,
   output logic                     o_output_valid,
   input  logic                     i_output_ready,
   output logic [WIDTH/RATIO-1:0]   o_output_data,
   output logic                     o_output_last
);

   localparam int OWIDTH = WIDTH / RATIO;
   localparam int CW     = $clog2(RATIO);
   localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                      r_state;
   logic [CW-1:0]               r_cnt;
   logic [WIDTH-1:0]            r_hold;

   logic                        w_busy;
   logic                        w_last;
   logic                        w_in_hs;
   logic                        w_out_hs;
   logic [RATIO-1:0][OWIDTH-1:0] w_slices;

   assign w_busy = (r_state == SHIFT);
   assign w_last = w_busy && (r_cnt == LAST_CNT);

   // Ready while idle, or when the final beat of the current word is leaving
   // this cycle, so a new word overlaps the last beat with no idle gap.
   assign o_input_ready = !i_reset && (!w_busy || (i_output_ready && w_last));

   // Outputs are gated by reset so nothing is presented or handshaken while
   // the block is being cleared (also masks the unknown state before the first reset).
   assign o_output_valid = w_busy && !i_reset;
   assign o_output_last  = w_last && !i_reset;

   // View the hold register as RATIO slices; slice 0 is the LSB slice.
   assign w_slices      = r_hold;
   assign o_output_data = w_slices[r_cnt];

   assign w_in_hs  = i_input_valid && o_input_ready;
   assign w_out_hs = o_output_valid && i_output_ready;

   // Control FSM: state and beat counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_in_hs) begin
                  r_state <= SHIFT;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               if (w_out_hs) begin
                  if (r_cnt == LAST_CNT) begin
                     // Last beat gone: either start the word taken in the
                     // same cycle, or fall back to idle.
                     r_cnt <= '0;
                     if (w_in_hs) begin
                        r_state <= SHIFT;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Data path: no reset on the hold register; its contents only matter
   // while busy, and a load can only happen outside reset because
   // o_input_ready is forced low during reset.
   always_ff @(posedge i_clk) begin
      if (w_in_hs) begin
         r_hold <= i_input_data;
      end
   end

endmodule
